fwd_table_ctl: RTL



---
 rtl/fwd_table_ctl_pkg.sv | 18 +
 rtl/fwd_table_mem.sv | 76 +++++++
 rtl/fwd_table_ctl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fwd_table_ctl_pkg.sv
// Shared definitions for the forwarding table slice.
//   PORT_NUM / PAYLOAD_W : entry field widths (port map in the upper bits,
//                          28-bit payload in the lower bits)
//   ENTRY_W              : full entry width
//   fsm_state_e          : background maintenance FSM states
package fwd_table_ctl_pkg;

  localparam int unsigned PORT_NUM  = 8;
  localparam int unsigned PAYLOAD_W = 28;
  localparam int unsigned ENTRY_W   = PORT_NUM + PAYLOAD_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_SWEEP = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/fwd_table_mem.sv
// Entry storage for the forwarding table: payload, age and valid per entry.
//   a_addr -> a_data/a_valid      : asynchronous read port (forwarding lookup)
//   b_addr -> b_data/b_valid      : asynchronous read port (host access)
//   host_we/host_addr/host_wdata  : host write (payload, valid=1, age=max)
//   ref_en/ref_addr               : reload age to max
//   maint_addr/flush_en/sweep_en  : background clear / age step on one entry
// Valid bits are reset; payload and age are not.
module fwd_table_mem
  import fwd_table_ctl_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = ENTRY_W,
  parameter int unsigned AGE_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_data,
  output logic              a_valid,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_data,
  output logic              b_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              ref_en,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic [ADDR_W-1:0] maint_addr,
  input  logic              flush_en,
  input  logic              sweep_en
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [AGE_W-1:0]  age_q  [DEPTH];

  logic sweep_ok, sweep_kill, sweep_dec;

  assign a_data  = data_q[a_addr];
  assign a_valid = valid_q[a_addr];
  assign b_data  = data_q[b_addr];
  assign b_valid = valid_q[b_addr];

  // A sweep step yields entirely to a host write or refresh of the same
  // entry, so a refreshed entry at age 0 is kept alive rather than killed.
  always_comb begin
    sweep_ok   = sweep_en && valid_q[maint_addr]
                 && !(ref_en && (ref_addr == maint_addr))
                 && !(host_we && (host_addr == maint_addr));
    sweep_kill = sweep_ok && (age_q[maint_addr] == '0);
    sweep_dec  = sweep_ok && (age_q[maint_addr] != '0);
  end

  // Later assignments win: host write has the final say.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (flush_en || sweep_kill) valid_q[maint_addr] <= 1'b0;
      if (host_we)                valid_q[host_addr]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sweep_dec) age_q[maint_addr] <= age_q[maint_addr] - AGE_W'(1);
    if (ref_en)    age_q[ref_addr]   <= AGE_MAX;
    if (host_we) begin
      data_q[host_addr] <= host_wdata;
      age_q[host_addr]  <= AGE_MAX;
    end
  end

endmodule

// File: rtl/fwd_table_ctl.sv
// Forwarding table controller.
//   fwd_*        : non-stalling lookup, result registered 1 cycle later,
//                  optional age refresh on hit
//   host_*       : req/ack read/write port, held off while flushing
//   flush_req    : invalidate every entry (DEPTH cycles)
//   age_tick     : one aging sweep over every entry (DEPTH cycles)
//   busy         : maintenance FSM not idle
//   sweep_done   : pulse when a sweep completes
//   tick_overrun : sticky, age_tick arrived while busy; cleared by flush_req
module fwd_table_ctl
  import fwd_table_ctl_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = ENTRY_W,
  parameter int unsigned AGE_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fwd_req,
  input  logic [ADDR_W-1:0] fwd_addr,
  input  logic              fwd_refresh,
  output logic              fwd_valid,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rhit,
  input  logic              flush_req,
  input  logic              age_tick,
  output logic              busy,
  output logic              sweep_done,
  output logic              tick_overrun
);

  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  fsm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              flush_en, sweep_en, done_d, ovr_set;
  logic              host_go, fwd_hit_d, host_hit_d, ref_en;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_valid, b_valid;

  fwd_table_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .AGE_W  (AGE_W)
  ) u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_addr     (fwd_addr),
    .a_data     (a_data),
    .a_valid    (a_valid),
    .b_addr     (host_addr),
    .b_data     (b_data),
    .b_valid    (b_valid),
    .host_we    (host_go && host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .ref_en     (ref_en),
    .ref_addr   (fwd_addr),
    .maint_addr (idx_q),
    .flush_en   (flush_en),
    .sweep_en   (sweep_en)
  );

  // !host_ack keeps a request still held during its ack cycle from
  // being served twice.
  assign host_go    = host_req && !host_ack && (state_q != ST_FLUSH);
  assign host_hit_d = host_go && !host_we && b_valid;
  assign fwd_hit_d  = fwd_req && a_valid;
  assign ref_en     = fwd_hit_d && fwd_refresh;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    flush_en = 1'b0;
    sweep_en = 1'b0;
    done_d   = 1'b0;
    ovr_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
          idx_d   = '0;
        end else if (age_tick) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_FLUSH: begin
        flush_en = 1'b1;
        ovr_set  = age_tick;
        if (flush_req) begin
          idx_d = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      ST_SWEEP: begin
        ovr_set = age_tick;
        if (flush_req) begin
          state_d = ST_FLUSH;
          idx_d   = '0;
        end else begin
          sweep_en = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      fwd_valid    <= 1'b0;
      fwd_hit      <= 1'b0;
      fwd_rdata    <= '0;
      host_ack     <= 1'b0;
      host_rhit    <= 1'b0;
      host_rdata   <= '0;
      sweep_done   <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fwd_valid  <= fwd_req;
      fwd_hit    <= fwd_hit_d;
      fwd_rdata  <= fwd_hit_d ? a_data : '0;
      host_ack   <= host_go;
      host_rhit  <= host_hit_d;
      host_rdata <= host_hit_d ? b_data : '0;
      sweep_done <= done_d;
      if (flush_req)    tick_overrun <= 1'b0;
      else if (ovr_set) tick_overrun <= 1'b1;
    end
  end

endmodule
